i2c_reg_slave: RTL and testbench
================================

# i2c_reg_slave

I2C target (slave) front end for the control plane: decodes the bus protocol on SCL/SDA and turns it into single-cycle register-file accesses. Sits directly upstream of `register_file`, driving its `reg_addr`/`reg_wdata`/`reg_wr`/`reg_rd` and sampling its combinational `reg_rdata`. Supports an 8-bit register pointer with auto-increment, burst writes, burst reads and repeated START.

## Interface
- `DEV_ADDR`, 7'h42: 7-bit target address the block ACKs.
- `FILTER_LEN`, 4: clk cycles a synchronized SCL/SDA level must be stable before it is accepted (range 2-15).
- `clk`  in  1  system clock, 100 MHz.
- `rst`  in  1  reset, **synchronous, active-high**. All state clears on the clk edge where `rst`=1.
- `scl_in`  in  1  raw SCL pad input, asynchronous.
- `sda_in`  in  1  raw SDA pad input, asynchronous.
- `sda_oe`  out  1  1 = pull SDA low (open-drain). Pad logic drives 0 when set, Z otherwise.
- `reg_addr`  out  8  register pointer, held between accesses.
- `reg_wdata`  out  8  write data, valid while `reg_wr`=1.
- `reg_wr`  out  1  one-cycle write strobe.
- `reg_rd`  out  1  one-cycle read strobe. `reg_rdata` is captured on the same cycle.
- `reg_rdata`  in  8  read data from the register file, combinational on `reg_addr`.
- `busy`  out  1  1 from an addressed-match ACK until STOP, START or NACK abort.

## Operation
- Input path: 2-FF synchronizer, then a stability filter of `FILTER_LEN` cycles, then edge detect. The detector produces `scl_rise`, `scl_fall`, `start` (SDA falls while SCL is high) and `stop` (SDA rises while SCL is high).
- Bits are sampled on `scl_rise`, MSB first. SDA is changed only on `scl_fall`.
- FSM states:
  - IDLE
  - ADDR: shift 8 bits.
  - ADDR_ACK
  - PTR: shift the pointer byte.
  - PTR_ACK
  - WR_DATA
  - WR_ACK
  - RD_LOAD
  - RD_DATA: shift out 8 bits.
  - RD_ACK: sample the master's ACK.
- `start` in any state goes to ADDR and clears the bit counter. `stop` in any state goes to IDLE and releases `sda_oe`. `reg_addr` is kept across both.
- ADDR, after 8 bits:
  - Address matches and R/W=0: go to ADDR_ACK, then PTR.
  - Address matches and R/W=1: go to ADDR_ACK, then RD_LOAD.
  - Address mismatch: no ACK, return to IDLE.
- PTR byte loads `reg_addr`, then PTR_ACK, then WR_DATA.
- WR_DATA, after 8 bits: on the 8th bit's `scl_rise`, the cycle after the sample sets `reg_wdata`=byte and pulses `reg_wr` for 1 cycle. `reg_addr` increments on the next cycle. Then WR_ACK, then WR_DATA.
- RD_LOAD: `reg_rd` pulses 1 cycle and the tx shifter captures `reg_rdata` on that cycle. `reg_addr` increments on the next cycle. Then RD_DATA.
- RD_ACK:
  - Master ACK (SDA=0): RD_LOAD.
  - Master NACK: IDLE (wait for STOP/START). `busy` drops.
- Pointer arithmetic is 8-bit unsigned and wraps 0xFF to 0x00.
- ACK drive: `sda_oe`=1 from the `scl_fall` ending bit 8 until the following `scl_fall`.
- Read drive: `sda_oe`=~bit, set on each `scl_fall`. Released on the `scl_fall` after bit 8 so the master can ACK.
- Simultaneous `start`/`stop` with a bit edge: the bus condition wins and the bit is discarded. No `reg_wr` fires for a partial byte.
- A STOP directly after the PTR byte sets the pointer only. A following repeated-START read then reads from that pointer.

## Timing
- Reset values: `sda_oe`=0, `reg_addr`=0x00, `reg_wdata`=0x00, `reg_wr`=0, `reg_rd`=0, `busy`=0, FSM=IDLE.
- Assertion of `rst` mid-transfer releases SDA on the same edge and ignores the bus until the next `start`.
- Input latency: pad to detected edge is 2 + `FILTER_LEN` clk.
- `sda_oe` changes exactly 1 clk after the detected `scl_fall`. This gives ≥ (3+`FILTER_LEN`)×10 ns hold, which is fine for 100/400 kHz.
- `reg_wr`/`reg_rd` are never asserted together, and each is at most once per byte.

## Structure
- `i2c_pkg`: FSM state enum `i2c_state_t`, `I2C_ACK`=1'b0, `I2C_NACK`=1'b1, and bit-count width.
- Sub-module `i2c_line_filter`: synchronizer, stability filter and edge/START/STOP detect. Instantiated once, covering both lines.
- Top contains the FSM, the shifters, the bit counter and the pointer.

## Test plan
- Write 0x20←0x5A (START, 0x84, 0x20, 0x5A, STOP) → three ACKs, one `reg_wr` pulse with `reg_addr`=0x20 and `reg_wdata`=0x5A, then `reg_addr`=0x21.
- Pointer 0x00, repeated START, 0x85, read 3 bytes (ACK, ACK, NACK) with the register-file model → SDA returns 0xA7, 0x01, 0x00. Three `reg_rd` pulses. `reg_addr` ends at 0x03.
- Address 0x86 (wrong target) → `sda_oe` stays 0 for the whole transfer, no strobes, `busy`=0.
- Burst write from pointer 0xFE with bytes 0x11, 0x22, 0x33 → writes land at 0xFE, 0xFF, 0x00. `reg_addr`=0x01.
- `rst` pulsed during bit 4 of a read byte → `sda_oe`=0 on the next edge. A following full write transaction behaves as in the first scenario.
- A 2-clk glitch on SCL with `FILTER_LEN`=4 → no bit sampled, and the transfer completes unchanged.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-access target.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_LOAD,
    ST_RD_DATA,
    ST_RD_ACK
  } i2c_state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam int BIT_CNT_W = 4;
  localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(7);
  localparam logic [BIT_CNT_W-1:0] BYTE_BITS = BIT_CNT_W'(8);

endpackage

// File: rtl/i2c_line_filter.sv
// Synchronizes and deglitches SCL/SDA, then reports clock edges and START/STOP.
module i2c_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  localparam logic [3:0] CNT_MAX = 4'(FILTER_LEN - 1);

  // Index 1 carries SCL, index 0 carries SDA.
  logic [1:0]      sync1;
  logic [1:0]      sync2;
  logic [1:0]      filt;
  logic [1:0]      filt_q;
  logic [1:0][3:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= '1;
      sync2  <= '1;
      filt   <= '1;
      filt_q <= '1;
      cnt    <= '0;
    end else begin
      sync1  <= {scl_in, sda_in};
      sync2  <= sync1;
      filt_q <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          filt[i] <= sync2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 4'd1;
        end
      end
    end
  end

  // START/STOP only need SCL to have been high; if SCL falls on the same
  // cycle the bus condition still fires and the FSM gives it priority.
  assign sda      = filt[0];
  assign scl_rise = filt[1] & ~filt_q[1];
  assign scl_fall = ~filt[1] & filt_q[1];
  assign start    = filt_q[1] & filt_q[0] & ~filt[0];
  assign stop     = filt_q[1] & ~filt_q[0] & filt[0];

endmodule

// File: rtl/i2c_reg_slave.sv
// I2C target that maps bus transfers onto single-cycle register-file strobes,
// with an auto-incrementing 8-bit pointer.
module i2c_reg_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR   = 7'h42,
  parameter int         FILTER_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output i2c_state_t state_dbg
);

  logic sda, scl_rise, scl_fall, start, stop;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk      (clk),
    .rst      (rst),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  i2c_state_t           state;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [6:0]           rx_sh;
  logic [7:0]           tx_sh;
  logic                 rw;
  logic [7:0]           rx_byte;
  logic                 shifting;
  logic                 byte_done;

  assign rx_byte   = {rx_sh, sda};
  assign shifting  = (state == ST_ADDR) || (state == ST_PTR) || (state == ST_WR_DATA);
  assign byte_done = scl_rise && shifting && (bit_cnt == BIT_LAST);
  assign state_dbg = state;

  // reg_wr/reg_rd are single-cycle strobes with no back-pressure: the register
  // file must accept a write and present reg_rdata in the cycle the strobe is
  // high. The pointer advances on the cycle after either strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      rx_sh     <= '0;
      tx_sh     <= '0;
      rw        <= 1'b0;
      sda_oe    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      reg_wr <= 1'b0;
      reg_rd <= 1'b0;
      if (reg_wr || reg_rd) reg_addr <= reg_addr + 8'd1;
      if (reg_rd) tx_sh <= reg_rdata;

      if (start) begin
        state   <= ST_ADDR;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else if (stop) begin
        state  <= ST_IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        if (scl_rise && shifting) begin
          rx_sh   <= rx_byte[6:0];
          bit_cnt <= byte_done ? '0 : bit_cnt + 1'b1;
        end

        unique case (state)
          ST_IDLE: ;
          ST_ADDR: begin
            if (byte_done) begin
              if (rx_byte[7:1] == DEV_ADDR) begin
                rw    <= rx_byte[0];
                busy  <= 1'b1;
                state <= ST_ADDR_ACK;
              end else begin
                state <= ST_IDLE;
              end
            end
          end
          ST_PTR: begin
            if (byte_done) begin
              reg_addr <= rx_byte;
              state    <= ST_PTR_ACK;
            end
          end
          ST_WR_DATA: begin
            if (byte_done) begin
              reg_wdata <= rx_byte;
              reg_wr    <= 1'b1;
              state     <= ST_WR_ACK;
            end
          end
          ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: begin
            // First fall starts the ACK pulse, the second one ends it.
            if (scl_rise && sda_oe && rw && state == ST_ADDR_ACK) begin
              state <= ST_RD_LOAD;
            end else if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else begin
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
                state   <= (state == ST_ADDR_ACK) ? ST_PTR : ST_WR_DATA;
              end
            end
          end
          ST_RD_LOAD: begin
            reg_rd  <= 1'b1;
            bit_cnt <= '0;
            state   <= ST_RD_DATA;
          end
          ST_RD_DATA: begin
            if (scl_fall) begin
              if (bit_cnt == BYTE_BITS) begin
                sda_oe <= 1'b0;
                state  <= ST_RD_ACK;
              end else begin
                sda_oe  <= ~tx_sh[7];
                tx_sh   <= {tx_sh[6:0], 1'b0};
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          ST_RD_ACK: begin
            if (scl_rise) begin
              if (sda == I2C_ACK) begin
                state <= ST_RD_LOAD;
              end else begin
                busy  <= 1'b0;
                state <= ST_IDLE;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Directed bench: bit-banged I2C master, register-file model and write scoreboard.
`timescale 1ns/1ps
module tb_i2c_reg_slave;
  import i2c_pkg::*;

  localparam int H = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m, sda_m;
  logic       sda_oe;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_wr, reg_rd, busy;
  i2c_state_t state_dbg;
  logic       sda_bus;

  logic [7:0]  rf [256];
  logic [15:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int wr_cnt = 0, rd_cnt = 0, both_cnt = 0, unexp_wr = 0;
  logic oe_seen, busy_seen;

  assign sda_bus   = sda_m & ~sda_oe;
  assign reg_rdata = rf[reg_addr];

  i2c_reg_slave #(.DEV_ADDR(7'h42), .FILTER_LEN(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .scl_in    (scl_m),
    .sda_in    (sda_bus),
    .sda_oe    (sda_oe),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .reg_rdata (reg_rdata),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // register-file model and scoreboard
  always @(posedge clk) if (reg_wr) rf[reg_addr] <= reg_wdata;

  always @(negedge clk) begin
    if (reg_wr) begin
      wr_cnt++;
      if (exp_q.size() == 0) unexp_wr++;
      else chk("wr_access", {16'h0, reg_addr, reg_wdata}, {16'h0, exp_q.pop_front()});
    end
    if (reg_rd) rd_cnt++;
    if (reg_wr && reg_rd) both_cnt++;
    if (sda_oe) oe_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
  end

  // driver tasks
  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    sda_m = b;
    wait_clks(8);
    if (glitch) begin
      scl_m = 1'b1;
      wait_clks(2);
      scl_m = 1'b0;
    end else begin
      wait_clks(2);
    end
    wait_clks(10);
    scl_m = 1'b1;
    wait_clks(H);
    scl_m = 1'b0;
    wait_clks(H / 2);
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1;
    wait_clks(H / 2);
    scl_m = 1'b1;
    wait_clks(H / 2);
    b = sda_bus;
    wait_clks(H / 2);
    scl_m = 1'b0;
    wait_clks(H / 2);
  endtask

  task automatic send_byte(input logic [7:0] b, input int glitch_idx, output logic ack);
    for (int i = 0; i < 8; i++) send_bit(b[7 - i], i == glitch_idx);
    recv_bit(ack);
  endtask

  task automatic recv_byte(input logic ack, output logic [7:0] d);
    logic bt;
    for (int i = 0; i < 8; i++) begin
      recv_bit(bt);
      d[7 - i] = bt;
    end
    send_bit(ack, 1'b0);
  endtask

  task automatic bus_start();
    sda_m = 1'b1;
    wait_clks(H / 2);
    scl_m = 1'b1;
    wait_clks(H / 2);
    sda_m = 1'b0;
    wait_clks(H / 2);
    scl_m = 1'b0;
    wait_clks(H / 2);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0;
    wait_clks(H / 2);
    scl_m = 1'b1;
    wait_clks(H / 2);
    sda_m = 1'b1;
    wait_clks(H);
  endtask

  task automatic write_txn(input logic [7:0] ptr, input logic [7:0] d, input int glitch_idx,
                           input string tag);
    logic ack;
    bus_start();
    send_byte(8'h84, -1, ack);
    chk({tag, "_addr_ack"}, ack, I2C_ACK);
    chk({tag, "_busy"}, busy, 1'b1);
    send_byte(ptr, glitch_idx, ack);
    chk({tag, "_ptr_ack"}, ack, I2C_ACK);
    send_byte(d, glitch_idx, ack);
    chk({tag, "_data_ack"}, ack, I2C_ACK);
    bus_stop();
  endtask

  // stimulus
  initial begin
    logic       ack, bt;
    logic [7:0] d;
    int         wr0, rd0;

    for (int i = 0; i < 256; i++) rf[i] = 8'h00;
    rf[0] = 8'hA7;
    rf[1] = 8'h01;
    rf[2] = 8'h00;
    scl_m = 1'b1;
    sda_m = 1'b1;
    rst   = 1'b1;
    wait_clks(5);
    rst = 1'b0;
    wait_clks(2);

    chk("rst_sda_oe", sda_oe, 1'b0);
    chk("rst_reg_addr", reg_addr, 8'h00);
    chk("rst_reg_wdata", reg_wdata, 8'h00);
    chk("rst_reg_wr", reg_wr, 1'b0);
    chk("rst_reg_rd", reg_rd, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_state", state_dbg, ST_IDLE);

    // single write 0x20 <- 0x5A
    exp_q.push_back({8'h20, 8'h5A});
    write_txn(8'h20, 8'h5A, -1, "wr1");
    chk("wr1_count", wr_cnt, 1);
    chk("wr1_ptr_after", reg_addr, 8'h21);
    chk("wr1_busy_after", busy, 1'b0);

    // pointer 0x00, repeated START, read three bytes
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    bus_start();
    send_byte(8'h84, -1, ack);
    chk("rd_addr_w_ack", ack, I2C_ACK);
    send_byte(8'h00, -1, ack);
    chk("rd_ptr_ack", ack, I2C_ACK);
    bus_start();
    send_byte(8'h85, -1, ack);
    chk("rd_addr_r_ack", ack, I2C_ACK);
    recv_byte(I2C_ACK, d);
    chk("rd_byte0", d, 8'hA7);
    recv_byte(I2C_ACK, d);
    chk("rd_byte1", d, 8'h01);
    recv_byte(I2C_NACK, d);
    chk("rd_byte2", d, 8'h00);
    chk("rd_busy_after_nack", busy, 1'b0);
    bus_stop();
    chk("rd_strobes", rd_cnt - rd0, 3);
    chk("rd_no_writes", wr_cnt - wr0, 0);
    chk("rd_ptr_after", reg_addr, 8'h03);

    // wrong target address
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    oe_seen   = 1'b0;
    busy_seen = 1'b0;
    bus_start();
    send_byte(8'h86, -1, ack);
    chk("bad_addr_nack", ack, I2C_NACK);
    send_byte(8'h00, -1, ack);
    chk("bad_data_nack", ack, I2C_NACK);
    bus_stop();
    chk("bad_oe_seen", oe_seen, 1'b0);
    chk("bad_busy_seen", busy_seen, 1'b0);
    chk("bad_strobes", (wr_cnt - wr0) + (rd_cnt - rd0), 0);
    chk("bad_ptr_kept", reg_addr, 8'h03);

    // burst write across pointer wrap
    exp_q.push_back({8'hFE, 8'h11});
    exp_q.push_back({8'hFF, 8'h22});
    exp_q.push_back({8'h00, 8'h33});
    bus_start();
    send_byte(8'h84, -1, ack);
    chk("burst_addr_ack", ack, I2C_ACK);
    send_byte(8'hFE, -1, ack);
    chk("burst_ptr_ack", ack, I2C_ACK);
    send_byte(8'h11, -1, ack);
    chk("burst_d0_ack", ack, I2C_ACK);
    send_byte(8'h22, -1, ack);
    chk("burst_d1_ack", ack, I2C_ACK);
    send_byte(8'h33, -1, ack);
    chk("burst_d2_ack", ack, I2C_ACK);
    bus_stop();
    chk("burst_ptr_after", reg_addr, 8'h01);
    chk("burst_q_empty", exp_q.size(), 0);

    // reset during bit 4 of a read byte (rf[1]=0x01, so bit 4 is driven low)
    bus_start();
    send_byte(8'h85, -1, ack);
    chk("rst_rd_addr_ack", ack, I2C_ACK);
    for (int i = 0; i < 3; i++) begin
      recv_bit(bt);
      chk("rst_rd_bit", bt, 1'b0);
    end
    sda_m = 1'b1;
    wait_clks(H / 2);
    scl_m = 1'b1;
    wait_clks(H / 4);
    chk("rst_rd_driving", sda_oe, 1'b1);
    rst = 1'b1;
    wait_clks(1);
    chk("rst_mid_sda_oe", sda_oe, 1'b0);
    chk("rst_mid_reg_addr", reg_addr, 8'h00);
    chk("rst_mid_busy", busy, 1'b0);
    rst = 1'b0;
    wait_clks(H / 2);
    scl_m = 1'b0;
    wait_clks(H / 2);
    bus_stop();
    exp_q.push_back({8'h20, 8'h5A});
    write_txn(8'h20, 8'h5A, -1, "wr2");
    chk("wr2_ptr_after", reg_addr, 8'h21);

    // 2-clk SCL glitch inside pointer and data bytes
    exp_q.push_back({8'h30, 8'hC3});
    write_txn(8'h30, 8'hC3, 3, "glitch");
    chk("glitch_ptr_after", reg_addr, 8'h31);
    chk("glitch_rf", rf[8'h30], 8'hC3);

    wait_clks(10);
    chk("final_q_empty", exp_q.size(), 0);
    chk("final_unexp_wr", unexp_wr, 0);
    chk("final_wr_rd_overlap", both_cnt, 0);
    chk("final_wr_total", wr_cnt, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
